sb_arbiter: RTL and testbench

// - Shares the single sb (system bus) port between the executrol load/store path (EX) and
//   the instruction fetch path (IF). One transaction is in flight at a time.
// - Sits between executrol/fetch and sb. Drives hold_o to pc while an EX access is outstanding.
// - EX has priority; after each EX transaction a pending IF request wins once (no fetch starvation).

---
 rtl/sb_arbiter.sv | 150 +++++++++++++++
 tb/tb_sb_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sb_arbiter.sv
// Two-master system-bus arbiter: EX load/store has priority, IF wins once after each EX access.
// Optional bus timeout abort is enabled with `define SB_ARB_TIMEOUT_EN.
module sb_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_req_i,
  input  logic              ex_we_i,
  input  logic [ADDR_W-1:0] ex_addr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  output logic              ex_ack_o,
  output logic [DATA_W-1:0] ex_rdata_o,
  output logic              ex_err_o,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_err_o,
  output logic              s_req_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_wdata_o,
  input  logic              s_ack_i,
  input  logic [DATA_W-1:0] s_rdata_i,
  output logic              hold_o
);

  typedef enum logic [1:0] {IDLE, BUSY_EX, BUSY_IF} state_t;

  state_t              state, state_n;
  logic                s_req_n, s_we_n;
  logic [ADDR_W-1:0]   s_addr_n;
  logic [DATA_W-1:0]   s_wdata_n;
  logic                ex_ack_n, ex_err_n, if_ack_n, if_err_n;
  logic [DATA_W-1:0]   ex_rdata_n, if_rdata_n;
  logic                if_turn, if_turn_n;
  logic                ex_pend, if_pend, grant, done, timeout_hit;

  assign hold_o = ex_req_i & ~ex_ack_o;

  // An owner's request is still high during its own ack cycle; mask it so it is not re-granted.
  assign ex_pend = ex_req_i & ~ex_ack_o;
  assign if_pend = if_req_i & ~if_ack_o;
  assign done    = s_ack_i | timeout_hit;

`ifdef SB_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt;

  assign timeout_hit = (state != IDLE) && !s_ack_i && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            cnt <= '0;
    else if (grant)                     cnt <= '0;
    else if (state != IDLE && !s_ack_i) cnt <= cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    s_req_n    = s_req_o;
    s_we_n     = s_we_o;
    s_addr_n   = s_addr_o;
    s_wdata_n  = s_wdata_o;
    ex_ack_n   = 1'b0;
    ex_err_n   = 1'b0;
    if_ack_n   = 1'b0;
    if_err_n   = 1'b0;
    ex_rdata_n = ex_rdata_o;
    if_rdata_n = if_rdata_o;
    if_turn_n  = if_turn;
    grant      = 1'b0;
    unique case (state)
      IDLE: begin
        if (ex_pend && (!if_pend || !if_turn)) begin
          grant     = 1'b1;
          state_n   = BUSY_EX;
          s_req_n   = 1'b1;
          s_we_n    = ex_we_i;
          s_addr_n  = ex_addr_i;
          s_wdata_n = ex_wdata_i;
        end else if (if_pend) begin
          grant     = 1'b1;
          state_n   = BUSY_IF;
          s_req_n   = 1'b1;
          s_we_n    = 1'b0;
          s_addr_n  = if_addr_i;
          s_wdata_n = '0;
        end
      end
      BUSY_EX: begin
        if (done) begin
          state_n    = IDLE;
          s_req_n    = 1'b0;
          ex_ack_n   = 1'b1;
          ex_err_n   = timeout_hit;
          ex_rdata_n = timeout_hit ? '0 : s_rdata_i;
          if_turn_n  = 1'b1;
        end
      end
      BUSY_IF: begin
        if (done) begin
          state_n    = IDLE;
          s_req_n    = 1'b0;
          if_ack_n   = 1'b1;
          if_err_n   = timeout_hit;
          if_rdata_n = timeout_hit ? '0 : s_rdata_i;
          if_turn_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      s_req_o    <= 1'b0;
      s_we_o     <= 1'b0;
      s_addr_o   <= '0;
      s_wdata_o  <= '0;
      ex_ack_o   <= 1'b0;
      ex_err_o   <= 1'b0;
      ex_rdata_o <= '0;
      if_ack_o   <= 1'b0;
      if_err_o   <= 1'b0;
      if_rdata_o <= '0;
      if_turn    <= 1'b0;
    end else begin
      state      <= state_n;
      s_req_o    <= s_req_n;
      s_we_o     <= s_we_n;
      s_addr_o   <= s_addr_n;
      s_wdata_o  <= s_wdata_n;
      ex_ack_o   <= ex_ack_n;
      ex_err_o   <= ex_err_n;
      ex_rdata_o <= ex_rdata_n;
      if_ack_o   <= if_ack_n;
      if_err_o   <= if_err_n;
      if_rdata_o <= if_rdata_n;
      if_turn    <= if_turn_n;
    end
  end

endmodule

// File: tb/tb_sb_arbiter.sv
// Directed self-checking bench for sb_arbiter; timeout scenarios run when SB_ARB_TIMEOUT_EN is defined.
module tb_sb_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_req_i, ex_we_i;
  logic [AW-1:0] ex_addr_i;
  logic [DW-1:0] ex_wdata_i;
  logic          ex_ack_o, ex_err_o;
  logic [DW-1:0] ex_rdata_o;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_ack_o, if_err_o;
  logic [DW-1:0] if_rdata_o;
  logic          s_req_o, s_we_o;
  logic [AW-1:0] s_addr_o;
  logic [DW-1:0] s_wdata_o;
  logic          s_ack_i;
  logic [DW-1:0] s_rdata_i;
  logic          hold_o;

  int n_cmp = 0;
  int n_bad = 0;

  sb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_req_i(ex_req_i), .ex_we_i(ex_we_i), .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i),
    .ex_ack_o(ex_ack_o), .ex_rdata_o(ex_rdata_o), .ex_err_o(ex_err_o),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_ack_i(s_ack_i), .s_rdata_i(s_rdata_i), .hold_o(hold_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ex_req_i = 1'b0; ex_we_i = 1'b0; ex_addr_i = '0; ex_wdata_i = '0;
    if_req_i = 1'b0; if_addr_i = '0; s_ack_i = 1'b0; s_rdata_i = '0;
    tick(); tick();
    n_cmp++; if (s_req_o !== 1'b0)  begin n_bad++; $display("FAIL reset_s_req got=%0h want=0", s_req_o); end
    n_cmp++; if (s_we_o !== 1'b0)   begin n_bad++; $display("FAIL reset_s_we got=%0h want=0", s_we_o); end
    n_cmp++; if (s_addr_o !== '0)   begin n_bad++; $display("FAIL reset_s_addr got=%0h want=0", s_addr_o); end
    n_cmp++; if (s_wdata_o !== '0)  begin n_bad++; $display("FAIL reset_s_wdata got=%0h want=0", s_wdata_o); end
    n_cmp++; if (ex_ack_o !== 1'b0) begin n_bad++; $display("FAIL reset_ex_ack got=%0h want=0", ex_ack_o); end
    n_cmp++; if (if_ack_o !== 1'b0) begin n_bad++; $display("FAIL reset_if_ack got=%0h want=0", if_ack_o); end
    n_cmp++; if (ex_err_o !== 1'b0 || if_err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%0h/%0h want=0/0", ex_err_o, if_err_o); end
    n_cmp++; if (ex_rdata_o !== '0 || if_rdata_o !== '0) begin n_bad++; $display("FAIL reset_rdata got=%0h/%0h want=0/0", ex_rdata_o, if_rdata_o); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ex_read();
    ex_req_i = 1'b1; ex_we_i = 1'b0; ex_addr_i = 32'h100;
    #1;
    n_cmp++; if (hold_o !== 1'b1) begin n_bad++; $display("FAIL rd_hold_c0 got=%0h want=1", hold_o); end
    tick();
    n_cmp++; if (s_req_o !== 1'b1)       begin n_bad++; $display("FAIL rd_s_req_c1 got=%0h want=1", s_req_o); end
    n_cmp++; if (s_addr_o !== 32'h100)   begin n_bad++; $display("FAIL rd_s_addr got=%0h want=100", s_addr_o); end
    n_cmp++; if (s_we_o !== 1'b0)        begin n_bad++; $display("FAIL rd_s_we got=%0h want=0", s_we_o); end
    n_cmp++; if (ex_ack_o !== 1'b0)      begin n_bad++; $display("FAIL rd_early_ack got=%0h want=0", ex_ack_o); end
    n_cmp++; if (hold_o !== 1'b1)        begin n_bad++; $display("FAIL rd_hold_c1 got=%0h want=1", hold_o); end
    s_ack_i = 1'b1; s_rdata_i = 32'hDEADBEEF;
    tick();
    s_ack_i = 1'b0; s_rdata_i = '0;
    n_cmp++; if (ex_ack_o !== 1'b1)           begin n_bad++; $display("FAIL rd_ack_c2 got=%0h want=1", ex_ack_o); end
    n_cmp++; if (ex_rdata_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_rdata got=%0h want=deadbeef", ex_rdata_o); end
    n_cmp++; if (ex_err_o !== 1'b0)           begin n_bad++; $display("FAIL rd_err got=%0h want=0", ex_err_o); end
    n_cmp++; if (s_req_o !== 1'b0)            begin n_bad++; $display("FAIL rd_s_req_c2 got=%0h want=0", s_req_o); end
    n_cmp++; if (hold_o !== 1'b0)             begin n_bad++; $display("FAIL rd_hold_c2 got=%0h want=0", hold_o); end
    ex_req_i = 1'b0;
    tick();
    n_cmp++; if (ex_ack_o !== 1'b0) begin n_bad++; $display("FAIL rd_ack_one_cycle got=%0h want=0", ex_ack_o); end
    n_cmp++; if (s_req_o !== 1'b0)  begin n_bad++; $display("FAIL rd_no_regrant got=%0h want=0", s_req_o); end
  endtask

  task automatic test_ex_write();
    int req_cycles = 0;
    int acks = 0;
    ex_req_i = 1'b1; ex_we_i = 1'b1; ex_addr_i = 32'h200; ex_wdata_i = 32'h12345678;
    tick();
    n_cmp++; if (s_we_o !== 1'b1)           begin n_bad++; $display("FAIL wr_s_we got=%0h want=1", s_we_o); end
    n_cmp++; if (s_wdata_o !== 32'h12345678) begin n_bad++; $display("FAIL wr_s_wdata got=%0h want=12345678", s_wdata_o); end
    ex_addr_i = 32'hFFF; ex_wdata_i = '0;
    for (int i = 0; i < 10; i++) begin
      if (s_req_o === 1'b1) req_cycles++;
      if (ex_ack_o === 1'b1) begin acks++; ex_req_i = 1'b0; end
      s_ack_i = (i == 3);
      tick();
    end
    s_ack_i = 1'b0; ex_we_i = 1'b0;
    n_cmp++; if (req_cycles != 4)      begin n_bad++; $display("FAIL wr_req_cycles got=%0d want=4", req_cycles); end
    n_cmp++; if (acks != 1)            begin n_bad++; $display("FAIL wr_ack_pulses got=%0d want=1", acks); end
    n_cmp++; if (s_addr_o !== 32'h200) begin n_bad++; $display("FAIL wr_addr_stable got=%0h want=200", s_addr_o); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq;
    int got = 0;
    logic [3:0] want = 4'b0101;
    seq = '0;
    rst = 1'b1; tick(); rst = 1'b0; tick();
    ex_req_i = 1'b1; ex_we_i = 1'b0; ex_addr_i = 32'h300;
    if_req_i = 1'b1; if_addr_i = 32'h400;
    for (int i = 0; i < 20; i++) begin
      if (got < 4 && ex_ack_o === 1'b1) begin
        seq[got] = 1'b1; got++;
        n_cmp++; if (ex_rdata_o !== 32'hA0000000 + DW'(i - 1)) begin n_bad++; $display("FAIL b2b_ex_rdata got=%0h want=%0h", ex_rdata_o, 32'hA0000000 + DW'(i - 1)); end
      end else if (got < 4 && if_ack_o === 1'b1) begin
        seq[got] = 1'b0; got++;
        n_cmp++; if (if_rdata_o !== 32'hA0000000 + DW'(i - 1)) begin n_bad++; $display("FAIL b2b_if_rdata got=%0h want=%0h", if_rdata_o, 32'hA0000000 + DW'(i - 1)); end
      end
      s_ack_i = s_req_o;
      s_rdata_i = 32'hA0000000 + DW'(i);
      tick();
    end
    ex_req_i = 1'b0; if_req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_ack_i = s_req_o;
      tick();
    end
    s_ack_i = 1'b0;
    n_cmp++; if (got != 4) begin n_bad++; $display("FAIL b2b_count got=%0d want=4", got); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (seq[k] !== want[k]) begin n_bad++; $display("FAIL b2b_order_%0d got=%0s want=%0s", k, seq[k] ? "EX" : "IF", want[k] ? "EX" : "IF"); end
    end
  endtask

  task automatic test_reset_mid();
    if_req_i = 1'b1; if_addr_i = 32'h500;
    tick();
    n_cmp++; if (s_req_o !== 1'b1 || s_addr_o !== 32'h500) begin n_bad++; $display("FAIL rstmid_busy got=%0h/%0h want=1/500", s_req_o, s_addr_o); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (s_req_o !== 1'b0)  begin n_bad++; $display("FAIL rstmid_s_req got=%0h want=0", s_req_o); end
    n_cmp++; if (if_ack_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_if_ack got=%0h want=0", if_ack_o); end
    n_cmp++; if (s_addr_o !== '0)   begin n_bad++; $display("FAIL rstmid_s_addr got=%0h want=0", s_addr_o); end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (s_req_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_regrant got=%0h want=1", s_req_o); end
    s_ack_i = 1'b1; s_rdata_i = 32'hCAFEF00D;
    tick();
    s_ack_i = 1'b0;
    n_cmp++; if (if_ack_o !== 1'b1)           begin n_bad++; $display("FAIL rstmid_ack got=%0h want=1", if_ack_o); end
    n_cmp++; if (if_rdata_o !== 32'hCAFEF00D) begin n_bad++; $display("FAIL rstmid_rdata got=%0h want=cafef00d", if_rdata_o); end
    n_cmp++; if (if_err_o !== 1'b0)           begin n_bad++; $display("FAIL rstmid_err got=%0h want=0", if_err_o); end
    if_req_i = 1'b0;
    tick();
    n_cmp++; if (if_ack_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_ack_one_cycle got=%0h want=0", if_ack_o); end
  endtask

`ifdef SB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int ack_c = -1;
    logic err_v = 1'b0;
    logic [DW-1:0] rd_v = '1;
    ex_req_i = 1'b1; ex_we_i = 1'b0; ex_addr_i = 32'h600; s_ack_i = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (ex_ack_o === 1'b1) begin ack_c = c; err_v = ex_err_o; rd_v = ex_rdata_o; break; end
    end
    ex_req_i = 1'b0;
    n_cmp++; if (ack_c != 17)  begin n_bad++; $display("FAIL to_ack_cycle got=%0d want=17", ack_c); end
    n_cmp++; if (err_v !== 1'b1) begin n_bad++; $display("FAIL to_err got=%0h want=1", err_v); end
    n_cmp++; if (rd_v !== '0)  begin n_bad++; $display("FAIL to_rdata got=%0h want=0", rd_v); end
    tick();
    n_cmp++; if (s_req_o !== 1'b0 || ex_ack_o !== 1'b0) begin n_bad++; $display("FAIL to_idle got=%0h/%0h want=0/0", s_req_o, ex_ack_o); end
  endtask

  task automatic test_timeout_edge();
    int ack_c = -1;
    logic err_v = 1'b1;
    logic [DW-1:0] rd_v = '0;
    ex_req_i = 1'b1; ex_we_i = 1'b0; ex_addr_i = 32'h700; s_rdata_i = 32'h55AA55AA;
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (ex_ack_o === 1'b1) begin ack_c = c; err_v = ex_err_o; rd_v = ex_rdata_o; break; end
      s_ack_i = (c == TO);
    end
    s_ack_i = 1'b0; ex_req_i = 1'b0;
    n_cmp++; if (ack_c != 17)          begin n_bad++; $display("FAIL toe_ack_cycle got=%0d want=17", ack_c); end
    n_cmp++; if (err_v !== 1'b0)       begin n_bad++; $display("FAIL toe_err got=%0h want=0", err_v); end
    n_cmp++; if (rd_v !== 32'h55AA55AA) begin n_bad++; $display("FAIL toe_rdata got=%0h want=55aa55aa", rd_v); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_ex_read();
    test_ex_write();
    test_back_to_back();
    test_reset_mid();
`ifdef SB_ARB_TIMEOUT_EN
    test_timeout();
    test_timeout_edge();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
